// File: rtl/aes_pkg.sv
// aes_pkg: block width, FSM encoding, AES S-box and GF(2^8) helpers shared
// by the cipher core and its round datapath.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Forward S-box, byte b lives at bits [8b +: 8] (row-major, 0x00 first).
  // This is the same table the upstream key expansion uses.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  // Multiply by {02} in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; col[31:24] is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_cipher_core_round.sv
// aes_round: one combinational AES encryption round. The final round skips
// MixColumns; every round ends with AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:BLOCK_W-1] state,
  input  logic [0:BLOCK_W-1] round_key,
  input  logic               final_round,
  output logic [0:BLOCK_W-1] next_state
);

  logic [0:BLOCK_W-1] sub_s;
  logic [0:BLOCK_W-1] shift_s;
  logic [0:BLOCK_W-1] mix_s;

  // SubBytes: S-box applied independently to all 16 bytes
  always_comb begin
    sub_s = '0;
    for (int k = 0; k < 16; k++) begin
      sub_s[8*k +: 8] = sbox(state[8*k +: 8]);
    end
  end

  // ShiftRows: row r of column c takes the byte from column (c+r) mod 4
  always_comb begin
    shift_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_s[8*(4*c+r) +: 8] = sub_s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
  end

  // MixColumns: each 32-bit column through the {02,03,01,01} circulant
  always_comb begin
    mix_s = '0;
    for (int c = 0; c < 4; c++) begin
      mix_s[32*c +: 32] = mix_column(shift_s[32*c +: 32]);
    end
  end

  // AddRoundKey on the MixColumns result, or on ShiftRows in the last round
  always_comb begin
    if (final_round) begin
      next_state = shift_s ^ round_key;
    end else begin
      next_state = mix_s ^ round_key;
    end
  end

endmodule

// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES encryption, one round per clock, with
// valid/ready handshakes on plaintext and ciphertext. Round keys come from
// the upstream expansion block and are not latched here.
module aes_cipher_core
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:128*(NR+1)-1] round_keys,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:BLOCK_W-1]    plaintext,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:BLOCK_W-1]    ciphertext,
  output logic                  busy
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  if (NR != NK + 6) begin : g_param_check
    $error("aes_cipher_core: NR must equal NK+6");
  end

  aes_state_e         state_r;
  logic [3:0]         rnd_r;
  logic [0:BLOCK_W-1] blk_r;
  logic [0:BLOCK_W-1] ct_r;
  logic               ov_r;
  logic               busy_r;
  logic [0:BLOCK_W-1] rk_s;
  logic [0:BLOCK_W-1] next_s;
  logic               final_s;
  logic [0:BLOCK_W-1] rk_arr_s [0:NR];

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk_arr_s[r] = round_keys[128*r +: 128];
  end

  // Select the key of the round currently being computed
  always_comb begin
    if (rnd_r <= LAST_RND) begin
      rk_s = rk_arr_s[rnd_r];
    end else begin
      rk_s = '0;
    end
  end

  assign final_s = (rnd_r == LAST_RND);

  aes_round u_round (
    .state       (blk_r),
    .round_key   (rk_s),
    .final_round (final_s),
    .next_state  (next_s)
  );

  // Ready when idle, or when the held result is being taken this cycle
  always_comb begin
    if (!rst_n) begin
      in_ready = 1'b0;
    end else if (state_r == ST_IDLE) begin
      in_ready = 1'b1;
    end else if (state_r == ST_DONE) begin
      in_ready = out_ready;
    end else begin
      in_ready = 1'b0;
    end
  end

  // Control FSM plus round state, round counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      rnd_r   <= 4'd0;
      blk_r   <= '0;
      ct_r    <= '0;
      ov_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            blk_r   <= plaintext ^ rk_arr_s[0];
            rnd_r   <= 4'd1;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (final_s) begin
            ct_r    <= next_s;
            ov_r    <= 1'b1;
            busy_r  <= 1'b0;
            rnd_r   <= 4'd0;
            state_r <= ST_DONE;
          end else begin
            blk_r <= next_s;
            rnd_r <= rnd_r + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            ov_r <= 1'b0;
            // A new block may be accepted on the same edge the result leaves
            if (in_valid) begin
              blk_r   <= plaintext ^ rk_arr_s[0];
              rnd_r   <= 4'd1;
              busy_r  <= 1'b1;
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rnd_r   <= 4'd0;
          ov_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ciphertext = ct_r;
  assign out_valid  = ov_r;
  assign busy       = busy_r;

endmodule
